// File: rtl/axil_cmd_sequencer.sv
// Command sequencer in front of the AXI-Lite master wrapper: buffers pushed
// read/write commands, issues them one at a time on the exec/fin port and
// returns each completion (or timeout) on a single-entry response port.
module axil_cmd_sequencer #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned TIMEOUT    = 64,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_we,
    input  logic [ADDR_W-1:0]      cmd_addr,
    input  logic [DATA_W-1:0]      cmd_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_we,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic                   m_exec,
    output logic                   m_we,
    output logic [ADDR_W-1:0]      m_address,
    output logic [DATA_W-1:0]      m_wdata,
    input  logic [DATA_W-1:0]      m_rdata,
    input  logic                   m_fin,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] cmd_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_FIN = 2'd1,
        S_RESP     = 2'd2,
        S_GAP      = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_fifo_we    [DEPTH];
    logic [ADDR_W-1:0]   r_fifo_addr  [DEPTH];
    logic [DATA_W-1:0]   r_fifo_wdata [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                w_push;
    logic                w_pop;

    logic [TMO_W-1:0]    r_tmo;
    logic [TMO_W-1:0]    w_tmo_nxt;
    logic [GAP_W-1:0]    r_gap;
    logic [GAP_W-1:0]    w_gap_nxt;

    logic                r_m_exec,    w_m_exec_nxt;
    logic                r_m_we,      w_m_we_nxt;
    logic [ADDR_W-1:0]   r_m_address, w_m_address_nxt;
    logic [DATA_W-1:0]   r_m_wdata,   w_m_wdata_nxt;
    logic                r_rsp_valid, w_rsp_valid_nxt;
    logic                r_rsp_we,    w_rsp_we_nxt;
    logic                r_rsp_err,   w_rsp_err_nxt;
    logic [DATA_W-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;

    assign cmd_ready = (r_count != CNT_W'(DEPTH));
    assign w_push    = cmd_valid && cmd_ready;
    assign cmd_count = r_count;
    assign busy      = (r_state != S_IDLE) || (r_count != CNT_W'(0));

    assign m_exec    = r_m_exec;
    assign m_we      = r_m_we;
    assign m_address = r_m_address;
    assign m_wdata   = r_m_wdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_we    = r_rsp_we;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

    // FIFO storage; contents are qualified by the count so no reset is needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_we[r_wr_ptr]    <= cmd_we;
            r_fifo_addr[r_wr_ptr]  <= cmd_addr;
            r_fifo_wdata[r_wr_ptr] <= cmd_wdata;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
        end
    end

    // FSM state, counters and registered driver/response outputs
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state     <= S_IDLE;
            r_tmo       <= '0;
            r_gap       <= '0;
            r_m_exec    <= 1'b0;
            r_m_we      <= 1'b0;
            r_m_address <= '0;
            r_m_wdata   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_we    <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_tmo       <= w_tmo_nxt;
            r_gap       <= w_gap_nxt;
            r_m_exec    <= w_m_exec_nxt;
            r_m_we      <= w_m_we_nxt;
            r_m_address <= w_m_address_nxt;
            r_m_wdata   <= w_m_wdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_we    <= w_rsp_we_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
        end
    end

    // Next-state and next-output logic; the driver port holds while waiting for fin
    always_comb begin
        w_state_nxt     = r_state;
        w_pop           = 1'b0;
        w_tmo_nxt       = r_tmo;
        w_gap_nxt       = r_gap;
        w_m_exec_nxt    = r_m_exec;
        w_m_we_nxt      = r_m_we;
        w_m_address_nxt = r_m_address;
        w_m_wdata_nxt   = r_m_wdata;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_we_nxt    = r_rsp_we;
        w_rsp_err_nxt   = r_rsp_err;
        w_rsp_rdata_nxt = r_rsp_rdata;

        case (r_state)
            S_IDLE: begin
                if (r_count != CNT_W'(0)) begin
                    w_pop           = 1'b1;
                    w_m_we_nxt      = r_fifo_we[r_rd_ptr];
                    w_m_address_nxt = r_fifo_addr[r_rd_ptr];
                    w_m_wdata_nxt   = r_fifo_wdata[r_rd_ptr];
                    w_m_exec_nxt    = 1'b1;
                    w_tmo_nxt       = '0;
                    w_state_nxt     = S_WAIT_FIN;
                end
            end
            S_WAIT_FIN: begin
                w_tmo_nxt = r_tmo + TMO_W'(1);
                if (m_fin) begin
                    w_m_exec_nxt    = 1'b0;
                    w_rsp_rdata_nxt = r_m_we ? '0 : m_rdata;
                    w_rsp_we_nxt    = r_m_we;
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = S_RESP;
                end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
                    w_m_exec_nxt    = 1'b0;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_we_nxt    = r_m_we;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_gap_nxt       = GAP_W'(GAP_CYCLES);
                    w_state_nxt     = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap <= GAP_W'(1)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_nxt = r_gap - GAP_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: doc/axil_cmd_sequencer.md
Name: axil_cmd_sequencer

Overview:
- Command front end sitting directly upstream of the AXI-Lite master wrapper.
- Accepts read/write commands from a test or CPU-side producer through a valid/ready push port and buffers them in a DEPTH-entry FIFO.
- Issues commands one at a time on the wrapper's exec/we/address/data/fin driver port.
- Returns each completion (read data or write ack, plus a timeout error flag) on a single-entry valid/ready response port.

Parameters:
- DATA_W, 32, data width; matches the wrapper's si_data/so_data.
- ADDR_W, 8, address width.
- DEPTH, 4, command FIFO entries; power of two, at least 2.
- TIMEOUT, 64, maximum cycles in WAIT_FIN before declaring an error; at least 4.
- GAP_CYCLES, 2, idle cycles with exec low between commands; at least 2.

Ports:
- clk  in  1  clock
- nreset  in  1  reset, asynchronous assert, active low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO not full
- cmd_we  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  command address
- cmd_wdata  in  DATA_W  write data; ignored for reads
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumer ready
- rsp_we  out  1  echo of the command's we
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  1 = timeout
- m_exec  out  1  start request to the wrapper
- m_we  out  1  to the wrapper's we
- m_address  out  ADDR_W  to the wrapper's si_address
- m_wdata  out  DATA_W  to the wrapper's si_data
- m_rdata  in  DATA_W  from the wrapper's so_data
- m_fin  in  1  one-cycle completion pulse from the wrapper
- busy  out  1  FSM not in IDLE, or FIFO non-empty
- cmd_count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (nreset low, asynchronous):
  - FIFO empty, pointers 0, cmd_count 0; cmd_ready is 1 once reset deasserts.
  - rsp_valid, rsp_we, rsp_err, rsp_rdata all 0.
  - m_exec, m_we, m_address, m_wdata all 0.
  - FSM returns to IDLE; timeout and gap counters cleared.
- Reset mid-operation aborts the in-flight command and drops all queued commands. No response is produced for them.
- FIFO:
  - Push on clk edge when cmd_valid && cmd_ready; cmd_ready = (cmd_count != DEPTH).
  - Pop only on the IDLE->WAIT_FIN transition.
  - Push and pop in the same cycle: count unchanged. Not possible while full, because ready is low.
  - Pointers wrap modulo DEPTH.
  - A command pushed into an empty FIFO is visible to the FSM on the next edge (no fall-through).
- IDLE:
  - If FIFO non-empty: pop the head and register m_we/m_address/m_wdata from it.
  - Set m_exec<=1, clear the timeout counter, go to WAIT_FIN.
- WAIT_FIN:
  - m_exec, m_we, m_address and m_wdata are held stable. This is required because the wrapper muxes fin on we.
  - Timeout counter increments every cycle.
  - On m_fin=1:
    - m_exec<=0.
    - rsp_rdata<=m_we ? 0 : m_rdata.
    - rsp_we<=m_we, rsp_err<=0, rsp_valid<=1.
    - Go to RESP.
  - If m_fin has not arrived and the counter reaches TIMEOUT-1:
    - m_exec<=0.
    - rsp_err<=1, rsp_rdata<=0, rsp_we<=m_we, rsp_valid<=1.
    - Go to RESP.
  - m_fin in the same cycle as the timeout: fin wins.
- RESP:
  - Outputs held until rsp_valid && rsp_ready at an edge.
  - On that edge: rsp_valid<=0, load the gap counter with GAP_CYCLES, go to GAP.
  - Back-pressure is unbounded; the FIFO keeps accepting pushes in the meantime.
- GAP:
  - m_exec stays low.
  - Counter decrements; on reaching 1, go to IDLE.
  - This guarantees the wrapper has returned to its idle state before the next exec.
- Stray m_fin outside WAIT_FIN is ignored.
- Minimum per-command cost with rsp_ready tied high: 1 (IDLE) + wrapper latency + 1 (RESP) + GAP_CYCLES.
- m_address and m_wdata retain their last values after completion; they are not cleared.

Test Plan:
- Reset, then push read addr 0x10; wrapper model returns 0xDEADBEEF with fin 3 cycles after exec -> exactly one rsp: rdata 0xDEADBEEF, we 0, err 0; m_exec high for exactly 3 cycles.
- Push write addr 0x04 data 0x12345678 with rsp_ready=1 -> m_we=1, m_wdata=0x12345678 stable while exec high; rsp: we 1, rdata 0, err 0.
- Push 5 commands back-to-back with DEPTH=4 and the wrapper stalled -> cmd_ready drops when cmd_count=4, refills as commands issue; 5 responses in push order.
- Model never raises fin -> rsp_err=1 after TIMEOUT cycles of exec; m_exec falls; the next queued command then issues normally.
- Hold rsp_ready=0 for 10 cycles after a read completes -> rsp_valid/rsp_rdata held; no new m_exec until the handshake plus GAP_CYCLES have elapsed.
- Assert nreset low while in WAIT_FIN with 2 commands queued -> m_exec=0 and cmd_count=0 immediately; no response produced after release.
